mem_access_arbiter: RTL and testbench

- N-requester front end to the single external memory port. Round-robin arbitration of read/write requests across ICache, DCache, flush-manager and future clients.
- Records which port owns each outstanding memory serial, and routes read data and write responses back to the owning port.
- Sits between the cache system and the memory-side serial/response interface.
- Generalises the current single-client memory access controller to parametric channel count, width and outstanding depth.

---
 rtl/mem_access_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin N-port front end to a single serial-tagged memory port
//
// Purpose:
//   Arbitrates read/write requests from NUM_PORTS clients onto one memory port.
//   Grants are combinational, so the request path adds no latency. The block
//   remembers which port owns each outstanding read/write serial, then routes
//   returned read data and write completions back to that port.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/we/addr/wdata  per-port request (port i at slice i)
//   req_ready           one-hot grant, same cycle as the request
//   rd_valid, rd_data   one-hot read return pulse, shared data bus
//   wr_ack              one-hot write completion pulse
//   mem_addr/wdata/re/we     request toward memory
//   mem_read_busy, mem_write_busy        memory back-pressure per type
//   next_read_serial, next_write_serial  serial the next accepted op receives
//   mem_read_data_ready/data/serial      read data return
//   mem_resp_valid/serial                write completion
//   orphan_resp         sticky flag: a response arrived for an unowned serial
//
// Optional feature macro: MEM_ARB_PERF_COUNTER_EN
//   Adds grant_count / stall_count outputs (32-bit saturating per port).

module mem_access_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int RD_SERIAL_WIDTH = 3,
  parameter int WR_SERIAL_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_PORTS-1:0]            wr_ack,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            mem_re,
  output logic                            mem_we,
  input  logic                            mem_read_busy,
  input  logic                            mem_write_busy,
  input  logic [RD_SERIAL_WIDTH-1:0]      next_read_serial,
  input  logic [WR_SERIAL_WIDTH-1:0]      next_write_serial,
  input  logic                            mem_read_data_ready,
  input  logic [DATA_WIDTH-1:0]           mem_read_data,
  input  logic [RD_SERIAL_WIDTH-1:0]      mem_read_serial,
  input  logic                            mem_resp_valid,
  input  logic [WR_SERIAL_WIDTH-1:0]      mem_resp_serial,
  output logic                            orphan_resp
`ifdef MEM_ARB_PERF_COUNTER_EN
  ,
  output logic [NUM_PORTS*32-1:0]         grant_count,
  output logic [NUM_PORTS*32-1:0]         stall_count
`endif
);

  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int RD_DEPTH = 1 << RD_SERIAL_WIDTH;
  localparam int WR_DEPTH = 1 << WR_SERIAL_WIDTH;

  logic [PW-1:0]         r_rr_ptr;
  logic [RD_DEPTH-1:0]   r_rd_own_valid;
  logic [PW-1:0]         r_rd_own_port [RD_DEPTH];
  logic [WR_DEPTH-1:0]   r_wr_own_valid;
  logic [PW-1:0]         r_wr_own_port [WR_DEPTH];
  logic [NUM_PORTS-1:0]  r_rd_valid;
  logic [NUM_PORTS-1:0]  r_wr_ack;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_orphan;

  logic                  w_rd_free;
  logic                  w_wr_free;
  logic [NUM_PORTS-1:0]  w_elig;
  logic                  w_gnt_found;
  logic [PW-1:0]         w_gnt_idx;
  logic [PW-1:0]         w_next_ptr;

  // A channel is free only if memory accepts it and the serial it would
  // receive is not still owned. An entry being retired this same cycle still
  // reads valid, so allocation onto it waits one cycle (no bypass).
  assign w_rd_free = !mem_read_busy  && !r_rd_own_valid[next_read_serial];
  assign w_wr_free = !mem_write_busy && !r_wr_own_valid[next_write_serial];

  // Gating with rst keeps every combinational request output at 0 in reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = rst && req_valid[i] && (req_we[i] ? w_wr_free : w_rd_free);
    end
  end

  // Cyclic priority scan starting at the round-robin pointer.
  always_comb begin : arb
    int v_idx;
    int v_nxt;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    v_idx       = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_PORTS;
      if (!w_gnt_found && w_elig[v_idx[PW-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = v_idx[PW-1:0];
      end
    end
    v_nxt      = (int'(w_gnt_idx) + 1) % NUM_PORTS;
    w_next_ptr = v_nxt[PW-1:0];
  end

  always_comb begin
    req_ready = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_found) begin
      req_ready[w_gnt_idx] = 1'b1;
      mem_addr = req_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      if (req_we[w_gnt_idx]) begin
        mem_we    = 1'b1;
        mem_wdata = req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        mem_re    = 1'b1;
      end
    end
  end

  // Retirement is processed before allocation. They can never target the same
  // entry: retirement needs a valid entry, allocation needs an invalid one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr       <= '0;
      r_rd_own_valid <= '0;
      r_wr_own_valid <= '0;
      for (int s = 0; s < RD_DEPTH; s++) r_rd_own_port[s] <= '0;
      for (int s = 0; s < WR_DEPTH; s++) r_wr_own_port[s] <= '0;
      r_rd_valid     <= '0;
      r_wr_ack       <= '0;
      r_rd_data      <= '0;
      r_orphan       <= 1'b0;
    end else begin
      r_rd_valid <= '0;
      r_wr_ack   <= '0;

      if (mem_read_data_ready) begin
        r_rd_data <= mem_read_data;
        if (r_rd_own_valid[mem_read_serial]) begin
          r_rd_valid[r_rd_own_port[mem_read_serial]] <= 1'b1;
          r_rd_own_valid[mem_read_serial]            <= 1'b0;
        end else begin
          r_orphan <= 1'b1;
        end
      end

      if (mem_resp_valid) begin
        if (r_wr_own_valid[mem_resp_serial]) begin
          r_wr_ack[r_wr_own_port[mem_resp_serial]] <= 1'b1;
          r_wr_own_valid[mem_resp_serial]          <= 1'b0;
        end else begin
          r_orphan <= 1'b1;
        end
      end

      if (w_gnt_found) begin
        r_rr_ptr <= w_next_ptr;
        if (req_we[w_gnt_idx]) begin
          r_wr_own_valid[next_write_serial] <= 1'b1;
          r_wr_own_port[next_write_serial]  <= w_gnt_idx;
        end else begin
          r_rd_own_valid[next_read_serial]  <= 1'b1;
          r_rd_own_port[next_read_serial]   <= w_gnt_idx;
        end
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign wr_ack      = r_wr_ack;
  assign orphan_resp = r_orphan;

`ifdef MEM_ARB_PERF_COUNTER_EN
  logic [31:0] r_grant_cnt [NUM_PORTS];
  logic [31:0] r_stall_cnt [NUM_PORTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_grant_cnt[i] <= '0;
        r_stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_ready[i] && (r_grant_cnt[i] != 32'hFFFF_FFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
        if (req_valid[i] && !req_ready[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    grant_count = '0;
    stall_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_count[i*32 +: 32] = r_grant_cnt[i];
      stall_count[i*32 +: 32] = r_stall_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - randomized self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

  localparam int NP  = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int RSW = 2;
  localparam int WSW = 1;
  localparam int RD_D = 1 << RSW;
  localparam int WR_D = 1 << WSW;

  logic clk = 1'b0;
  logic rst_n;
  logic [NP-1:0]    req_valid, req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_ready, rd_valid, wr_ack;
  logic [DW-1:0]    rd_data, mem_wdata;
  logic [AW-1:0]    mem_addr;
  logic             mem_re, mem_we;
  logic             mem_read_busy, mem_write_busy;
  logic [RSW-1:0]   next_read_serial, mem_read_serial;
  logic [WSW-1:0]   next_write_serial, mem_resp_serial;
  logic             mem_read_data_ready, mem_resp_valid;
  logic [DW-1:0]    mem_read_data;
  logic             orphan_resp;
`ifdef MEM_ARB_PERF_COUNTER_EN
  logic [NP*32-1:0] grant_count, stall_count;
`endif

  mem_access_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_SERIAL_WIDTH(RSW), .WR_SERIAL_WIDTH(WSW)
  ) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_read_busy(mem_read_busy), .mem_write_busy(mem_write_busy),
    .next_read_serial(next_read_serial), .next_write_serial(next_write_serial),
    .mem_read_data_ready(mem_read_data_ready), .mem_read_data(mem_read_data),
    .mem_read_serial(mem_read_serial), .mem_resp_valid(mem_resp_valid),
    .mem_resp_serial(mem_resp_serial), .orphan_resp(orphan_resp)
`ifdef MEM_ARB_PERF_COUNTER_EN
    , .grant_count(grant_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner table per serial (-1 = free), rotating priority start.
  int own_rd[RD_D];
  int own_wr[WR_D];
  int m_ptr;
  bit m_orphan;
  logic [NP-1:0] m_rd_valid, m_wr_ack;
  logic [DW-1:0] m_rd_data;
  int m_last_gnt;
  int m_gcnt[NP];
  int m_scnt[NP];

  function automatic void model_reset();
    foreach (own_rd[s]) own_rd[s] = -1;
    foreach (own_wr[s]) own_wr[s] = -1;
    m_ptr = 0; m_orphan = 1'b0; m_rd_valid = '0; m_wr_ack = '0; m_rd_data = '0;
    m_last_gnt = -1;
    foreach (m_gcnt[p]) begin m_gcnt[p] = 0; m_scnt[p] = 0; end
  endfunction

  function automatic int exp_grant();
    int g;
    g = -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      bit free;
      p = (m_ptr + k) % NP;
      if (req_we[p]) free = !mem_write_busy && (own_wr[next_write_serial] < 0);
      else           free = !mem_read_busy  && (own_rd[next_read_serial] < 0);
      if (g < 0 && req_valid[p] && free) g = p;
    end
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int g;
      g = exp_grant();
      m_last_gnt = g;
      for (int p = 0; p < NP; p++) begin
        if (g == p) m_gcnt[p]++;
        else if (req_valid[p]) m_scnt[p]++;
      end
      m_rd_valid = '0;
      m_wr_ack   = '0;
      if (mem_read_data_ready) begin
        if (own_rd[mem_read_serial] >= 0) begin
          m_rd_valid[own_rd[mem_read_serial]] = 1'b1;
          m_rd_data = mem_read_data;
          own_rd[mem_read_serial] = -1;
        end else m_orphan = 1'b1;
      end
      if (mem_resp_valid) begin
        if (own_wr[mem_resp_serial] >= 0) begin
          m_wr_ack[own_wr[mem_resp_serial]] = 1'b1;
          own_wr[mem_resp_serial] = -1;
        end else m_orphan = 1'b1;
      end
      if (g >= 0) begin
        if (req_we[g]) own_wr[next_write_serial] = g;
        else           own_rd[next_read_serial]  = g;
        m_ptr = (g + 1) % NP;
      end
    end
  end

  // Single compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int g;
      logic [NP-1:0] er;
      g = exp_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", req_ready, er);
      if (g >= 0) begin
        check("mem_re", mem_re, !req_we[g]);
        check("mem_we", mem_we, req_we[g]);
        check("mem_addr", mem_addr, req_addr[g*AW +: AW]);
        check("mem_wdata", mem_wdata, req_we[g] ? req_wdata[g*DW +: DW] : '0);
      end else begin
        check("mem_re_idle", mem_re, 1'b0);
        check("mem_we_idle", mem_we, 1'b0);
      end
      check("rd_valid", rd_valid, m_rd_valid);
      if (m_rd_valid != '0) check("rd_data", rd_data, m_rd_data);
      check("wr_ack", wr_ack, m_wr_ack);
      check("orphan_resp", orphan_resp, m_orphan);
`ifdef MEM_ARB_PERF_COUNTER_EN
      for (int p = 0; p < NP; p++) begin
        check("grant_count", grant_count[p*32 +: 32], 32'(m_gcnt[p]));
        check("stall_count", stall_count[p*32 +: 32], 32'(m_scnt[p]));
      end
`endif
    end
  end

  task automatic rand_cycle(input int req_pct, input int resp_pct);
    int vs[$];
    if (m_last_gnt >= 0) begin
      if (req_we[m_last_gnt]) next_write_serial = next_write_serial + 1'b1;
      else                    next_read_serial  = next_read_serial + 1'b1;
      req_valid[m_last_gnt] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      if (!req_valid[p] && ($urandom_range(99) < req_pct)) begin
        req_valid[p] = 1'b1;
        req_we[p]    = 1'($urandom_range(1));
        req_addr[p*AW +: AW]  = AW'($urandom);
        req_wdata[p*DW +: DW] = $urandom;
      end
    end
    mem_read_busy  = ($urandom_range(99) < 15);
    mem_write_busy = ($urandom_range(99) < 15);
    mem_read_data_ready = 1'b0;
    mem_resp_valid      = 1'b0;
    vs.delete();
    for (int s = 0; s < RD_D; s++) if (own_rd[s] >= 0) vs.push_back(s);
    if (vs.size() > 0 && $urandom_range(99) < resp_pct) begin
      mem_read_data_ready = 1'b1;
      mem_read_serial     = RSW'(vs[$urandom_range(vs.size() - 1)]);
      mem_read_data       = $urandom;
    end
    vs.delete();
    for (int s = 0; s < WR_D; s++) if (own_wr[s] >= 0) vs.push_back(s);
    if (vs.size() > 0 && $urandom_range(99) < resp_pct) begin
      mem_resp_valid  = 1'b1;
      mem_resp_serial = WSW'(vs[$urandom_range(vs.size() - 1)]);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_read_busy = 1'b0; mem_write_busy = 1'b0;
    next_read_serial = '0; next_write_serial = '0;
    mem_read_data_ready = 1'b0; mem_read_data = '0; mem_read_serial = '0;
    mem_resp_valid = 1'b0; mem_resp_serial = '0;
    req_addr[0*AW +: AW] = 16'h0100;
    req_addr[1*AW +: AW] = 16'h0200;
    req_addr[2*AW +: AW] = 16'h0300;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_rd_valid", rd_valid, 3'b000);
    check("rst_wr_ack", wr_ack, 3'b000);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_orphan", orphan_resp, 1'b0);
    req_valid = '0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #2;

    // Two ports reading every cycle: grants alternate starting from port 0.
    req_valid = 3'b011;
    #1;
    check("t1_gnt0", req_ready, 3'b001);
    check("t1_addr0", mem_addr, 16'h0100);
    @(posedge clk); #2;
    next_read_serial = 2'd1;
    #1;
    check("t1_gnt1", req_ready, 3'b010);
    check("t1_addr1", mem_addr, 16'h0200);
    @(posedge clk); #2;
    req_valid = '0;
    next_read_serial = 2'd2;
    check("t1_model_own0", own_rd[0], 0);
    check("t1_model_own1", own_rd[1], 1);

    // Out-of-order returns routed to owners.
    mem_read_data_ready = 1'b1; mem_read_serial = 2'd1; mem_read_data = 32'hAAAA_AAAA;
    @(posedge clk); #2;
    mem_read_serial = 2'd0; mem_read_data = 32'hBBBB_BBBB;
    #1;
    check("t2_rv_a", rd_valid, 3'b010);
    check("t2_rd_a", rd_data, 32'hAAAA_AAAA);
    @(posedge clk); #2;
    mem_read_data_ready = 1'b0;
    #1;
    check("t2_rv_b", rd_valid, 3'b001);
    check("t2_rd_b", rd_data, 32'hBBBB_BBBB);
    @(posedge clk); #2;
    check("t2_pulse", rd_valid, 3'b000);

    // Return and allocation on the same serial: no bypass, grant next cycle.
    req_valid = 3'b100;
    @(posedge clk); #2;
    req_valid = 3'b001;
    mem_read_data_ready = 1'b1; mem_read_serial = 2'd2; mem_read_data = 32'hCCCC_CCCC;
    #1;
    check("t4_blocked", req_ready, 3'b000);
    check("t4_no_re", mem_re, 1'b0);
    @(posedge clk); #2;
    mem_read_data_ready = 1'b0;
    #1;
    check("t4_rv", rd_valid, 3'b100);
    check("t4_rd", rd_data, 32'hCCCC_CCCC);
    check("t4_gnt", req_ready, 3'b001);
    @(posedge clk); #2;
    req_valid = '0;
    next_read_serial = 2'd3;
    @(posedge clk); #2;

    repeat (1500) rand_cycle(40, 50);
    repeat (1500) rand_cycle(60, 10);

    // Mid-operation reset, then a late response: orphan, no routing.
    rst_n = 1'b0;
    req_valid = '0; mem_read_data_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_read_busy = 1'b0; mem_write_busy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    next_read_serial = '0; next_write_serial = '0;
    mem_read_data_ready = 1'b1; mem_read_serial = 2'd0; mem_read_data = 32'hDDDD_DDDD;
    @(posedge clk); #2;
    mem_read_data_ready = 1'b0;
    #1;
    check("t5_no_rv", rd_valid, 3'b000);
    check("t5_orphan", orphan_resp, 1'b1);
    @(posedge clk); #2;
    check("t5_orphan_sticky", orphan_resp, 1'b1);

    // Port 0 alone for 10 cycles, read side busy for the first 4.
    for (int c = 0; c < 10; c++) begin
      req_valid = 3'b001; req_we = '0;
      mem_read_busy = (c < 4);
      @(posedge clk); #2;
      mem_read_data_ready = 1'b0;
      if (m_last_gnt == 0) begin
        mem_read_data_ready = 1'b1;
        mem_read_serial     = next_read_serial;
        mem_read_data       = $urandom;
        next_read_serial    = next_read_serial + 1'b1;
      end
    end
    req_valid = '0; mem_read_busy = 1'b0;
    check("t6_model_gcnt", m_gcnt[0], 6);
    check("t6_model_scnt", m_scnt[0], 4);
`ifdef MEM_ARB_PERF_COUNTER_EN
    check("t6_grant_count0", grant_count[31:0], 32'd6);
    check("t6_stall_count0", stall_count[31:0], 32'd4);
`endif
    @(posedge clk); #2;
    mem_read_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("t6_orphan_end", orphan_resp, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
